// File: rtl/dmem_initiator.sv
// dmem_initiator: single-outstanding initiator between a requester and a
// 16-bit word-addressed data memory with combinational read data.
// Each accepted request is latched, spends one cycle in ACCESS driving the
// memory strobes, then waits in RESP until the response is consumed.
// Optional feature: define DMEM_ADDR_CHECK_EN so that accesses outside
// words 0..7 are answered with rsp_err=1 and never reach the memory.
//
// Handshake semantics: a transfer happens on a rising clk edge where
// valid and ready are both high. Once rsp_valid is high, rsp_rdata and
// rsp_err hold until rsp_ready is sampled high. req_* inputs are only
// looked at on an edge where req_valid && req_ready.
module dmem_initiator (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] mem_access_addr,
   output logic [15:0] mem_write_data,
   output logic        mem_write_en,
   output logic        mem_read,
   input  logic [15:0] mem_read_data,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state;
   logic        we_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic        addr_err;
   logic        req_fire;

   // Address range check on the latched address; without the option every
   // address goes to the memory and aliases on its low three bits.
`ifdef DMEM_ADDR_CHECK_EN
   assign addr_err = |addr_q[15:3];
`else
   assign addr_err = 1'b0;
`endif

   // Request acceptance: idle, or the current response is retiring this cycle.
   assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
   assign req_fire  = req_valid && req_ready;
   assign rsp_valid = (state == RESP);

   // Memory strobes only in ACCESS; gated by rst_n so that a reset landing
   // mid-access never lets a write or read through.
   assign mem_write_en = rst_n && (state == ACCESS) && we_q  && !addr_err;
   assign mem_read     = rst_n && (state == ACCESS) && !we_q && !addr_err;

   assign mem_access_addr = addr_q;
   assign mem_write_data  = wdata_q;
   assign dbg_state       = state;

   // FSM with request latch and response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         addr_q    <= 16'h0000;
         wdata_q   <= 16'h0000;
         rsp_rdata <= 16'h0000;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_fire) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               // Response data is captured on the edge that ends the access.
               if (addr_err) begin
                  rsp_rdata <= 16'h0000;
                  rsp_err   <= 1'b1;
               end else if (we_q) begin
                  rsp_rdata <= 16'h0000;
                  rsp_err   <= 1'b0;
               end else begin
                  rsp_rdata <= mem_read_data;
                  rsp_err   <= 1'b0;
               end
               state <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  if (req_valid) begin
                     we_q    <= req_we;
                     addr_q  <= req_addr;
                     wdata_q <= req_wdata;
                     state   <= ACCESS;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_initiator.sv
// tb_dmem_initiator: directed plus randomized bench for dmem_initiator.
// An 8-word memory model sits on the memory port; a reference memory and an
// expected-response queue predict every response from the access rules.
`timescale 1ns/1ps
module tb_dmem_initiator;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic [15:0] mem_access_addr;
   logic [15:0] mem_write_data;
   logic        mem_write_en;
   logic        mem_read;
   logic [15:0] mem_read_data;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   logic [15:0] tb_mem  [0:7];
   logic [15:0] ref_mem [0:7];
   logic [15:0] exp_q[$];
   logic        exp_err_q[$];

   dmem_initiator dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_we          (req_we),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .mem_access_addr (mem_access_addr),
      .mem_write_data  (mem_write_data),
      .mem_write_en    (mem_write_en),
      .mem_read        (mem_read),
      .mem_read_data   (mem_read_data),
      .dbg_state       (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Memory model: commits on rising clk, reads combinationally, junk when idle
   initial for (int i = 0; i < 8; i++) tb_mem[i] = 16'h0000;
   always @(posedge clk) if (mem_write_en) tb_mem[mem_access_addr[2:0]] <= mem_write_data;
   assign mem_read_data = mem_read ? tb_mem[mem_access_addr[2:0]] : 16'hDEAD;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic addr_is_bad(input logic [15:0] a);
`ifdef DMEM_ADDR_CHECK_EN
      return (a > 16'd7);
`else
      return 1'b0;
`endif
   endfunction

   // Reference model: apply one request to the reference memory and queue its response
   task automatic model_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      if (addr_is_bad(addr)) begin
         exp_q.push_back(16'h0000);
         exp_err_q.push_back(1'b1);
      end else if (we) begin
         ref_mem[addr % 8] = wdata;
         exp_q.push_back(16'h0000);
         exp_err_q.push_back(1'b0);
      end else begin
         exp_q.push_back(ref_mem[addr % 8]);
         exp_err_q.push_back(1'b0);
      end
   endtask

   // Driver: one full transaction from IDLE with a given response stall
   task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input int stall);
      logic [15:0] d;
      logic        e;
      logic        bad;
      bad = addr_is_bad(addr);
      model_req(we, addr, wdata);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      check("idle_req_ready", req_ready, 1'b1);
      tick();
      // ACCESS: scramble the request inputs, they must be ignored
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      check("acc_state", dbg_state, 2'd1);
      check("acc_we", mem_write_en, we && !bad);
      check("acc_rd", mem_read, !we && !bad);
      check("acc_addr", mem_access_addr, addr);
      check("acc_wdata", mem_write_data, wdata);
      check("acc_rsp_valid", rsp_valid, 1'b0);
      check("acc_req_ready", req_ready, 1'b0);
      tick();
      req_valid = 1'b0;
      d = exp_q.pop_front();
      e = exp_err_q.pop_front();
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_rdata", rsp_rdata, d);
      check("rsp_err", rsp_err, e);
      check("rsp_strobes", {mem_write_en, mem_read}, 2'b00);
      for (int s = 0; s < stall; s++) begin
         check("stall_req_ready", req_ready, 1'b0);
         tick();
         check("stall_rsp_valid", rsp_valid, 1'b1);
         check("stall_rdata", rsp_rdata, d);
         check("stall_err", rsp_err, e);
         check("stall_strobes", {mem_write_en, mem_read}, 2'b00);
      end
      rsp_ready = 1'b1;
      #1;
      check("retire_req_ready", req_ready, 1'b1);
      tick();
      rsp_ready = 1'b0;
      check("post_rsp_valid", rsp_valid, 1'b0);
      check("post_state", dbg_state, 2'd0);
   endtask

   initial begin
      logic [15:0] old5;
      logic [15:0] w;
      logic [15:0] d;
      logic        e;
      int          stall;
      logic        we;
      logic [15:0] a;

      for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = 16'h0; req_wdata = 16'h0; rsp_ready = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_state", dbg_state, 2'd0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rdata", rsp_rdata, 16'h0000);
      check("rst_err", rsp_err, 1'b0);
      check("rst_addr", mem_access_addr, 16'h0000);
      check("rst_wdata", mem_write_data, 16'h0000);
      check("rst_strobes", {mem_write_en, mem_read}, 2'b00);
      rst_n = 1'b1;
      #1;
      check("rst_req_ready", req_ready, 1'b1);
      tick();

      // Store then load at word 3
      do_txn(1'b1, 16'd3, 16'hBEEF, 0);
      check("store_mem3", tb_mem[3], 16'hBEEF);
      do_txn(1'b0, 16'd3, 16'h0000, 2);

      // Backpressure for 5 cycles
      do_txn(1'b0, 16'd3, 16'h1234, 5);

      // Fill words 0..3 with random data, then back-to-back loads
      for (int i = 0; i < 4; i++) do_txn(1'b1, 16'(i), 16'($urandom), 0);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'd0;
      for (int i = 0; i < 4; i++) begin
         model_req(1'b0, 16'(i), 16'h0000);
         tick();
         check("b2b_acc_state", dbg_state, 2'd1);
         check("b2b_rd", mem_read, 1'b1);
         check("b2b_addr", mem_access_addr, 16'(i));
         if (i < 3) req_addr = 16'(i + 1);
         else req_valid = 1'b0;
         tick();
         d = exp_q.pop_front();
         e = exp_err_q.pop_front();
         check("b2b_rsp_valid", rsp_valid, 1'b1);
         check("b2b_rdata", rsp_rdata, d);
         check("b2b_err", rsp_err, e);
         check("b2b_req_ready", req_ready, 1'b1);
      end
      tick();
      rsp_ready = 1'b0;
      check("b2b_end_state", dbg_state, 2'd0);

      // Reset arriving mid-ACCESS of a store to word 5
      old5      = ref_mem[5];
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'd5;
      req_wdata = ~old5;
      tick();
      req_valid = 1'b0;
      check("rsta_state", dbg_state, 2'd1);
      check("rsta_we_pre", mem_write_en, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rsta_we_gated", mem_write_en, 1'b0);
      tick();
      check("rsta_state_idle", dbg_state, 2'd0);
      check("rsta_rsp_valid", rsp_valid, 1'b0);
      rst_n = 1'b1;
      #1;
      check("rsta_req_ready", req_ready, 1'b1);
      tick();
      check("rsta_no_rsp", rsp_valid, 1'b0);
      check("rsta_mem5", tb_mem[5], old5);
      do_txn(1'b0, 16'd5, 16'h0000, 1);

      // Out-of-range store to 0x0008
      w = 16'($urandom);
      do_txn(1'b1, 16'h0008, w, 0);
      check("oor_mem0", tb_mem[0], ref_mem[0]);
      do_txn(1'b0, 16'd0, 16'h0000, 0);

      // Randomized traffic
      for (int n = 0; n < 30; n++) begin
         we    = 1'($urandom_range(0, 1));
         stall = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) a = 16'($urandom);
         else a = 16'($urandom_range(0, 7));
         do_txn(we, a, 16'($urandom), stall);
      end

      for (int i = 0; i < 8; i++) check("final_mem", tb_mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
